// File: rtl/crc_link_pkg.sv
// ---------------------------------------------------------------------------
// crc_link_pkg
// Shared definitions for the serial CRC-3 link:
//   - state_t     : frame sequencer states
//   - CRC3_POLY   : generator polynomial x^3 + x + 1
//   - RETRY_W     : width of the retransmission counter
//   - crc3_step() : one serial update of a CRC-3 register (used by the
//                   generator/checker blocks that sit beside the sequencer)
// ---------------------------------------------------------------------------
package crc_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND_DATA = 3'd2,
    ST_SEND_CRC  = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DONE      = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  localparam logic [3:0] CRC3_POLY = 4'b1011;
  localparam int         RETRY_W   = 32'sd2;

  // Serial CRC-3 update: the feedback bit is the register MSB xor the
  // incoming bit; when set, the low polynomial taps are folded back in.
  function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic din);
    logic       fb;
    logic [2:0] shifted;
    fb      = crc[2] ^ din;
    shifted = {crc[1:0], 1'b0};
    crc3_step = fb ? (shifted ^ CRC3_POLY[2:0]) : shifted;
  endfunction

endpackage

// File: rtl/crc_link_bit_counter.sv
// ---------------------------------------------------------------------------
// crc_link_bit_counter
// Loadable up-counter holding the bit index within a frame.
// Ports:
//   i_clk       : clock
//   i_rst       : synchronous active-high reset
//   i_clr       : synchronous clear (below reset in priority)
//   i_load      : load i_load_val
//   i_load_val  : value to load
//   i_inc       : increment by one
//   o_cnt       : registered count
//   o_tc_data   : count equals DATA_BITS-1 (last data bit)
//   o_tc_frame  : count equals DATA_BITS+CRC_BITS-1 (last CRC bit)
// ---------------------------------------------------------------------------
module crc_link_bit_counter
  import crc_link_pkg::*;
#(
  parameter int DATA_BITS = 32'sd8,
  parameter int CRC_BITS  = 32'sd3,
  parameter int CNT_W     = 32'sd4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc_data,
  output logic             o_tc_frame
);

  localparam logic [CNT_W-1:0] TC_DATA  = CNT_W'(DATA_BITS - 32'sd1);
  localparam logic [CNT_W-1:0] TC_FRAME = CNT_W'(DATA_BITS + CRC_BITS - 32'sd1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(32'sd1);

  logic [CNT_W-1:0] r_cnt;

  // Bit index register: reset/clear to zero, load, or count up.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc) begin
      r_cnt <= r_cnt + ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_tc_data  = (r_cnt == TC_DATA);
  assign o_tc_frame = (r_cnt == TC_FRAME);

endmodule

// File: rtl/crc_link_sequencer.sv
// ---------------------------------------------------------------------------
// crc_link_sequencer
// Frame-level controller for the serial CRC-3 link. For each frame it loads
// the data shift register, shifts DATA_BITS data bits and CRC_BITS CRC bits
// onto the line, samples the checker error flag and retransmits up to
// MAX_RETRY times before declaring a sticky failure.
// Ports:
//   CLK        : clock, rising edge
//   CLR        : synchronous active-high reset (highest priority)
//   Start      : frame request, honoured in IDLE or FAIL
//   Abort      : abort frame in progress
//   Error      : CRC checker error flag, sampled in CHECK
//   Load       : parallel-load strobe to data shift register
//   Gen_Clr    : clear CRC generator
//   Chk_Clr    : clear CRC checker
//   Shift_En   : shift enable for shift register / generator / checker
//   Select     : 0 = data bit to line, 1 = CRC bits to line
//   Bit_Cnt    : bit index within the frame (0 outside the shift phases)
//   Retry_Cnt  : retransmissions performed for the current request
//   Busy       : frame sequence in progress
//   Done       : one-cycle pulse on error-free completion
//   Fail       : retry budget exhausted (sticky)
// All outputs are registered decodes of the next state.
// ---------------------------------------------------------------------------
module crc_link_sequencer
  import crc_link_pkg::*;
#(
  parameter int DATA_BITS = 32'sd8,
  parameter int CRC_BITS  = 32'sd3,
  parameter int MAX_RETRY = 32'sd2,
  parameter int CNT_W     = 32'sd4
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               Start,
  input  logic               Abort,
  input  logic               Error,
  output logic               Load,
  output logic               Gen_Clr,
  output logic               Chk_Clr,
  output logic               Shift_En,
  output logic               Select,
  output logic [CNT_W-1:0]   Bit_Cnt,
  output logic [RETRY_W-1:0] Retry_Cnt,
  output logic               Busy,
  output logic               Done,
  output logic               Fail
);

  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(32'sd1);

  state_t               r_state;
  state_t               w_next;
  logic [RETRY_W-1:0]   r_retry;
  logic                 w_tc_data;
  logic                 w_tc_frame;
  logic                 w_cnt_clr;
  logic                 w_cnt_load;
  logic                 w_cnt_inc;
  logic                 w_cur_send;
  logic                 w_next_send;

  // Next-state decision; Abort only matters while a frame is in flight.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Start) w_next = ST_LOAD;
        else       w_next = ST_IDLE;
      end
      ST_LOAD: begin
        if (Abort) w_next = ST_IDLE;
        else       w_next = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        if (Abort)          w_next = ST_IDLE;
        else if (w_tc_data) w_next = ST_SEND_CRC;
        else                w_next = ST_SEND_DATA;
      end
      ST_SEND_CRC: begin
        if (Abort)           w_next = ST_IDLE;
        else if (w_tc_frame) w_next = ST_CHECK;
        else                 w_next = ST_SEND_CRC;
      end
      ST_CHECK: begin
        if (Abort)                  w_next = ST_IDLE;
        else if (!Error)            w_next = ST_DONE;
        else if (r_retry < RETRY_MAX) w_next = ST_LOAD;
        else                        w_next = ST_FAIL;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      ST_FAIL: begin
        if (Start) w_next = ST_LOAD;
        else       w_next = ST_FAIL;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Bit counter control: count only while staying in the shift phases, so
  // Bit_Cnt reads zero everywhere else (including after an abort).
  always_comb begin
    w_cur_send  = (r_state == ST_SEND_DATA) || (r_state == ST_SEND_CRC);
    w_next_send = (w_next == ST_SEND_DATA) || (w_next == ST_SEND_CRC);
    w_cnt_load  = (r_state == ST_LOAD) && (w_next == ST_SEND_DATA);
    w_cnt_inc   = w_cur_send && w_next_send;
    w_cnt_clr   = !w_next_send;
  end

  crc_link_bit_counter #(
    .DATA_BITS (DATA_BITS),
    .CRC_BITS  (CRC_BITS),
    .CNT_W     (CNT_W)
  ) u_bit_counter (
    .i_clk      (CLK),
    .i_rst      (CLR),
    .i_clr      (w_cnt_clr),
    .i_load     (w_cnt_load),
    .i_load_val ({CNT_W{1'b0}}),
    .i_inc      (w_cnt_inc),
    .o_cnt      (Bit_Cnt),
    .o_tc_data  (w_tc_data),
    .o_tc_frame (w_tc_frame)
  );

  // State, retry count and Moore outputs registered together from w_next.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state  <= ST_IDLE;
      r_retry  <= {RETRY_W{1'b0}};
      Load     <= 1'b0;
      Gen_Clr  <= 1'b0;
      Chk_Clr  <= 1'b0;
      Shift_En <= 1'b0;
      Select   <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Fail     <= 1'b0;
    end else begin
      r_state <= w_next;
      // A fresh request restarts the budget; a retry from CHECK spends one.
      if (((r_state == ST_IDLE) || (r_state == ST_FAIL)) && (w_next == ST_LOAD)) begin
        r_retry <= {RETRY_W{1'b0}};
      end else if ((r_state == ST_CHECK) && (w_next == ST_LOAD)) begin
        r_retry <= r_retry + RETRY_ONE;
      end else begin
        r_retry <= r_retry;
      end
      Load     <= (w_next == ST_LOAD);
      Gen_Clr  <= (w_next == ST_LOAD);
      Chk_Clr  <= (w_next == ST_LOAD);
      Shift_En <= (w_next == ST_SEND_DATA) || (w_next == ST_SEND_CRC);
      Select   <= (w_next == ST_SEND_CRC);
      Busy     <= (w_next == ST_LOAD) || (w_next == ST_SEND_DATA) ||
                  (w_next == ST_SEND_CRC) || (w_next == ST_CHECK);
      Done     <= (w_next == ST_DONE);
      Fail     <= (w_next == ST_FAIL);
    end
  end

  assign Retry_Cnt = r_retry;

endmodule

// File: tb/tb_crc_link_sequencer.sv
// ---------------------------------------------------------------------------
// tb_crc_link_sequencer
// Self-checking bench for crc_link_sequencer. The reference model tracks a
// request as "an attempt in flight at cycle offset N" plus done/fail flags;
// every output is derived arithmetically from that offset each cycle.
// ---------------------------------------------------------------------------
module tb_crc_link_sequencer;

  localparam int DATA_BITS = 8;
  localparam int CRC_BITS  = 3;
  localparam int MAX_RETRY = 2;
  localparam int CNT_W     = 4;
  // Offsets within one attempt: 0 load, 1..11 shifting, 12 check.
  localparam int CHECK_OFF = DATA_BITS + CRC_BITS + 1;

  logic             CLK = 1'b0;
  logic             CLR = 1'b1;
  logic             Start = 1'b0;
  logic             Abort = 1'b0;
  logic             Error = 1'b0;
  logic             Load, Gen_Clr, Chk_Clr, Shift_En, Select, Busy, Done, Fail;
  logic [CNT_W-1:0] Bit_Cnt;
  logic [1:0]       Retry_Cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_fail   = 1'b0;
  int m_off    = 0;
  int m_retry  = 0;

  crc_link_sequencer #(
    .DATA_BITS (DATA_BITS),
    .CRC_BITS  (CRC_BITS),
    .MAX_RETRY (MAX_RETRY),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .Start     (Start),
    .Abort     (Abort),
    .Error     (Error),
    .Load      (Load),
    .Gen_Clr   (Gen_Clr),
    .Chk_Clr   (Chk_Clr),
    .Shift_En  (Shift_En),
    .Select    (Select),
    .Bit_Cnt   (Bit_Cnt),
    .Retry_Cnt (Retry_Cnt),
    .Busy      (Busy),
    .Done      (Done),
    .Fail      (Fail)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled there.
  function automatic void model_update(input logic c, input logic s, input logic a, input logic e);
    if (c) begin
      m_active = 1'b0; m_done = 1'b0; m_fail = 1'b0; m_off = 0; m_retry = 0;
    end else if (m_active) begin
      if (a) begin
        m_active = 1'b0; m_off = 0;
      end else if (m_off < CHECK_OFF) begin
        m_off++;
      end else if (!e) begin
        m_active = 1'b0; m_done = 1'b1; m_off = 0;
      end else if (m_retry < MAX_RETRY) begin
        m_retry++; m_off = 0;
      end else begin
        m_active = 1'b0; m_fail = 1'b1; m_off = 0;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (s) begin
      m_active = 1'b1; m_off = 0; m_retry = 0; m_fail = 1'b0;
    end
  endfunction

  task automatic compare_all();
    bit ld_e, sh_e, sel_e;
    int cnt_e;
    ld_e  = m_active && (m_off == 0);
    sh_e  = m_active && (m_off >= 1) && (m_off <= DATA_BITS + CRC_BITS);
    sel_e = m_active && (m_off > DATA_BITS) && (m_off <= DATA_BITS + CRC_BITS);
    cnt_e = sh_e ? (m_off - 1) : 0;
    check_eq("Load",      32'(Load),      32'(ld_e));
    check_eq("Gen_Clr",   32'(Gen_Clr),   32'(ld_e));
    check_eq("Chk_Clr",   32'(Chk_Clr),   32'(ld_e));
    check_eq("Shift_En",  32'(Shift_En),  32'(sh_e));
    check_eq("Select",    32'(Select),    32'(sel_e));
    check_eq("Bit_Cnt",   32'(Bit_Cnt),   32'(cnt_e));
    check_eq("Retry_Cnt", 32'(Retry_Cnt), 32'(m_retry));
    check_eq("Busy",      32'(Busy),      32'(m_active));
    check_eq("Done",      32'(Done),      32'(m_done));
    check_eq("Fail",      32'(Fail),      32'(m_fail));
  endtask

  // Drive inputs (called at a falling edge), clock once, then compare.
  task automatic step(input logic c, input logic s, input logic a, input logic e);
    CLR = c; Start = s; Abort = a; Error = e;
    @(posedge CLK);
    model_update(c, s, a, e);
    @(negedge CLK);
    compare_all();
  endtask

  // Modes: 0 clean, 1 one retry, 2 exhaust, 3 abort at Bit_Cnt=5,
  // 4 CLR mid-CRC on the retry, 5 Start held high, 6 random.
  task automatic run_phase(input int mode, input int cycles);
    logic c, s, a, e;
    bit   in_check;
    for (int i = 0; i < cycles; i++) begin
      in_check = m_active && (m_off == CHECK_OFF);
      c = 1'b0; s = 1'b0; a = 1'b0;
      e = 1'($urandom_range(0, 1));
      case (mode)
        0: begin s = (i == 0); if (in_check) e = 1'b0; end
        1: begin s = (i == 0); if (in_check) e = (m_retry == 0); end
        2: begin s = (i == 0); e = 1'b1; end
        3: begin
          s = (i == 0); a = (i == 0) || (m_active && (m_off == 6));
          if (in_check) e = 1'b0;
        end
        4: begin
          s = (i == 0); if (in_check) e = (m_retry == 0);
          c = m_active && (m_retry == 1) && (m_off == 10);
        end
        5: begin s = 1'b1; if (in_check) e = 1'b0; end
        default: begin
          s = ($urandom_range(0, 7) == 0);
          a = ($urandom_range(0, 63) == 0);
          c = ($urandom_range(0, 127) == 0);
        end
      endcase
      step(c, s, a, e);
    end
  endtask

  initial begin
    // Reset held two cycles with Start high: Start must be ignored.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_phase(0, 20);
    run_phase(1, 35);
    run_phase(2, 50);
    run_phase(0, 20);   // Start from FAIL clears Fail and Retry_Cnt
    run_phase(3, 20);
    run_phase(4, 35);
    run_phase(5, 45);
    run_phase(6, 3000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
